// File: rtl/step_pulse_gen_pkg.sv
// Shared constants for the step pulse generator and the 2-bit step counter.
// Holds the state encoding and the compile-time sizing helpers.
package step_pulse_gen_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HIGH = 2'b01;
  localparam logic [1:0] S_LOW  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_HIGH = S_HIGH,
    ST_LOW  = S_LOW,
    ST_DONE = S_DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Control/status bundle between the pulse source and the pulse generator.
interface step_pulse_gen_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] n;
  logic         x_out;
  logic         busy;
  logic         done;
  logic [W-1:0] sent;

  modport master (
    output start, n,
    input  x_out, busy, done, sent
  );

  modport slave (
    input  start, n,
    output x_out, busy, done, sent
  );
endinterface

// File: rtl/step_pulse_gen_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, which marks
// the last cycle of the current phase.
module step_pulse_gen_phase_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          tc
);
  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - ONE;
  end

  assign tc = (cnt_q == '0);
endmodule

// File: rtl/step_pulse_gen.sv
// Emits n well-separated pulses on x_out per accepted start, so a downstream
// edge-triggered counter advances exactly n steps.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int W        = 4,
  parameter int HIGH_CYC = 2,
  parameter int LOW_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  step_pulse_gen_if.slave  bus
);
  localparam int TW = clog2(max2(HIGH_CYC, LOW_CYC) + 1);
  localparam logic [W-1:0]  ONE    = W'(1);
  localparam logic [TW-1:0] HI_TOP = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] LO_TOP = TW'(LOW_CYC - 1);

  state_e        state_q, state_nx;
  logic [W-1:0]  rem_q, rem_nx;
  logic [W-1:0]  sent_q, sent_nx;
  logic          x_q, busy_q, done_q;
  logic          tmr_tc, tmr_load;
  logic [TW-1:0] tmr_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_nx;
      rem_q   <= rem_nx;
      sent_q  <= sent_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    rem_nx   = rem_q;
    sent_nx  = sent_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sent_nx = '0;
          if (bus.n != '0) begin
            rem_nx   = bus.n;
            state_nx = ST_HIGH;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_tc) begin
          state_nx = ST_LOW;
          rem_nx   = rem_q - ONE;
          sent_nx  = sent_q + ONE;
        end
      end
      ST_LOW: begin
        // rem_q was already decremented when this pulse's high phase ended
        if (tmr_tc) state_nx = (rem_q != '0) ? ST_HIGH : ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Every phase change (including LOW->HIGH) restarts the timer.
  assign tmr_load = (state_nx != state_q);
  assign tmr_val  = (state_nx == ST_HIGH) ? HI_TOP : LO_TOP;

  step_pulse_gen_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Outputs registered from next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= (state_nx == ST_HIGH);
      busy_q <= (state_nx == ST_HIGH) || (state_nx == ST_LOW);
      done_q <= (state_nx == ST_DONE);
    end
  end

  assign bus.x_out = x_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sent  = sent_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench: default-timing generator plus a 1/1-timing instance, each
// feeding a model of the downstream 2-bit step counter.
module tb_step_pulse_gen;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  step_pulse_gen_if #(.W(4)) bus_a ();
  step_pulse_gen_if #(.W(4)) bus_b ();

  step_pulse_gen #(.W(4), .HIGH_CYC(2), .LOW_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  step_pulse_gen #(.W(4), .HIGH_CYC(1), .LOW_CYC(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Downstream 2-bit counter: advances on a low->high change of x seen at clk.
  logic [1:0] cnt_a, cnt_b;
  logic       xq_a, xq_b;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a <= 2'b00; cnt_b <= 2'b00; xq_a <= 1'b0; xq_b <= 1'b0;
    end else begin
      xq_a <= bus_a.x_out;
      xq_b <= bus_b.x_out;
      if (bus_a.x_out && !xq_a) cnt_a <= cnt_a + 2'b01;
      if (bus_b.x_out && !xq_b) cnt_b <= cnt_b + 2'b01;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat, rises, dones;
    logic px;
    rst = 1'b0;
    bus_a.start = 1'b0; bus_a.n = '0;
    bus_b.start = 1'b0; bus_b.n = '0;

    // Reset
    repeat (3) tick();
    chk("rst_x",    bus_a.x_out, 0);
    chk("rst_busy", bus_a.busy,  0);
    chk("rst_done", bus_a.done,  0);
    chk("rst_sent", bus_a.sent,  0);
    rst = 1'b1;
    tick();

    // n=5 chained: counter 00 -> 01
    bus_a.start = 1'b1; bus_a.n = 4'd5;
    tick();
    bus_a.start = 1'b0;
    lat = 0;
    while (!bus_a.done && lat < 200) begin tick(); lat++; end
    chk("n5_latency", lat, 20);
    chk("n5_sent",    bus_a.sent, 5);
    chk("n5_cnt",     cnt_a, 2'b01);
    tick();
    chk("n5_done_1cyc", bus_a.done, 0);

    // n=3 full waveform: 2 high / 2 low per pulse, done at 12
    bus_a.start = 1'b1; bus_a.n = 4'd3;
    tick();
    bus_a.start = 1'b0; bus_a.n = 4'd9;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("n3_x_k%0d", k),    bus_a.x_out, ((k % 4) < 2) ? 1 : 0);
      chk($sformatf("n3_busy_k%0d", k), bus_a.busy, 1);
      chk($sformatf("n3_done_k%0d", k), bus_a.done, 0);
      chk($sformatf("n3_sent_k%0d", k), bus_a.sent, (k + 2) / 4);
      tick();
    end
    chk("n3_done",  bus_a.done, 1);
    chk("n3_busy0", bus_a.busy, 0);
    chk("n3_x0",    bus_a.x_out, 0);
    chk("n3_sent",  bus_a.sent, 3);
    chk("n3_cnt",   cnt_a, 2'b00);
    tick();
    chk("n3_idle_done", bus_a.done, 0);
    chk("n3_sent_hold", bus_a.sent, 3);

    // n=0: straight to DONE, no pulse
    bus_a.start = 1'b1; bus_a.n = 4'd0;
    tick();
    bus_a.start = 1'b0;
    chk("n0_done", bus_a.done, 1);
    chk("n0_busy", bus_a.busy, 0);
    chk("n0_x",    bus_a.x_out, 0);
    chk("n0_sent", bus_a.sent, 0);
    tick();
    chk("n0_done_off", bus_a.done, 0);
    chk("n0_x_off",    bus_a.x_out, 0);

    // n=2 with a start/n=7 pulse mid-job: ignored
    bus_a.start = 1'b1; bus_a.n = 4'd2;
    tick();
    bus_a.start = 1'b0;
    rises = 1; px = bus_a.x_out; lat = 0;
    while (!bus_a.done && lat < 200) begin
      if (lat == 3) begin bus_a.start = 1'b1; bus_a.n = 4'd7; end
      else begin bus_a.start = 1'b0; end
      tick(); lat++;
      if (bus_a.x_out && !px) rises++;
      px = bus_a.x_out;
    end
    bus_a.start = 1'b0;
    chk("rs_latency", lat, 8);
    chk("rs_pulses",  rises, 2);
    chk("rs_sent",    bus_a.sent, 2);
    chk("rs_cnt",     cnt_a, 2'b10);
    tick();
    tick();
    chk("rs_no_requeue", bus_a.busy, 0);

    // 1/1 timing, n=15: alternating for 30 cycles, done once at 30
    bus_b.start = 1'b1; bus_b.n = 4'd15;
    tick();
    bus_b.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("b_x_k%0d", k), bus_b.x_out, (k % 2 == 0) ? 1 : 0);
      if (bus_b.done) dones++;
      tick();
    end
    chk("b_done", bus_b.done, 1);
    dones += bus_b.done ? 1 : 0;
    tick();
    dones += bus_b.done ? 1 : 0;
    chk("b_done_once", dones, 1);
    chk("b_sent",      bus_b.sent, 15);
    chk("b_cnt",       cnt_b, 2'b11);

    // Reset mid-HIGH: x_out drops without a clock edge, no done
    bus_a.start = 1'b1; bus_a.n = 4'd4;
    tick();
    bus_a.start = 1'b0;
    chk("mr_in_high", bus_a.x_out, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_x_async",    bus_a.x_out, 0);
    chk("mr_busy_async", bus_a.busy, 0);
    chk("mr_sent_async", bus_a.sent, 0);
    tick();
    chk("mr_done", bus_a.done, 0);
    rst = 1'b1;
    tick();
    chk("mr_idle_x",    bus_a.x_out, 0);
    chk("mr_idle_busy", bus_a.busy, 0);
    chk("mr_idle_done", bus_a.done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
